// File: rtl/hall_commutator.sv
// Hall sensor decoder and six-step commutation driver for one BLDC motor.
// Raw Hall inputs are synchronised and debounced. Each accepted code is mapped
// to a commutation step, checked for legal sequencing and timed for the speed
// loop. The bridge is blanked on invalid codes, sequence errors, stall or
// when the motor is disabled. Every output comes straight from a flop.
module hall_commutator #(
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned STALL_CYCLES = 100000,
  parameter int unsigned PERIOD_W     = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                dir_i,
  input  logic [2:0]          hall_i,
  output logic [5:0]          status_o,
  output logic [2:0]          step_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                period_valid_o,
  output logic                fault_o,
  output logic                stall_o
);

  localparam int unsigned         DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0]     DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};

  // Forward-sequence code to step map; invalid codes never reach a step update.
  function automatic logic [2:0] code_to_step(input logic [2:0] code);
    logic [2:0] s;
    s = 3'd0;
    case (code)
      3'b001:  s = 3'd0;
      3'b011:  s = 3'd1;
      3'b010:  s = 3'd2;
      3'b110:  s = 3'd3;
      3'b100:  s = 3'd4;
      3'b101:  s = 3'd5;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  // Forward drive {AH,AL,BH,BL,CH,CL}; reverse uses the step three places on,
  // which is the same phase pair with high and low sides exchanged.
  function automatic logic [5:0] drive_pattern(input logic [2:0] step);
    logic [5:0] p;
    p = 6'b000000;
    case (step)
      3'd0:    p = 6'b100100;
      3'd1:    p = 6'b100001;
      3'd2:    p = 6'b001001;
      3'd3:    p = 6'b011000;
      3'd4:    p = 6'b010010;
      3'd5:    p = 6'b000110;
      default: p = 6'b000000;
    endcase
    return p;
  endfunction

  logic [2:0]          sync1_q, sync2_q;
  logic [2:0]          cand_q;
  logic [DB_W-1:0]     db_cnt_q;
  logic [2:0]          acc_code_q;
  logic [2:0]          step_q;
  logic [PERIOD_W-1:0] cnt_q, period_q;
  logic                pv_q, inv_q, seq_q, stall_q;
  logic                have_prev_q, exempt_q;
  logic [5:0]          status_q;

  logic                accept, code_ok, step_chg, bad_code, stalled, adjacent;
  logic [2:0]          new_step, step_d, acc_code_d, drive_step;
  logic [PERIOD_W-1:0] cnt_d, period_d;
  logic                pv_d, inv_d, seq_d, stall_d, have_prev_d, exempt_d, live;
  logic [5:0]          status_d;

  // Two-flop synchroniser for the asynchronous Hall pins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= hall_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: restart on any change, count stable cycles up to DEBOUNCE-1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cand_q   <= 3'b000;
      db_cnt_q <= '0;
    end else if (sync2_q != cand_q) begin
      cand_q   <= sync2_q;
      db_cnt_q <= '0;
    end else if (db_cnt_q != DB_LAST) begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  // Acceptance, sequencing, period, stall and bridge drive next-state logic.
  always_comb begin
    accept   = (sync2_q == cand_q) && (db_cnt_q == DB_LAST) && (cand_q != acc_code_q);
    code_ok  = (cand_q != 3'b000) && (cand_q != 3'b111);
    step_chg = accept && code_ok;
    bad_code = accept && !code_ok;
    new_step = code_to_step(cand_q);
    // Stalled means the threshold was already reached before this edge.
    stalled  = 32'(cnt_q) >= STALL_CYCLES;
    adjacent = (new_step == ((step_q == 3'd5) ? 3'd0 : step_q + 3'd1)) ||
               (new_step == ((step_q == 3'd0) ? 3'd5 : step_q - 3'd1));

    acc_code_d = accept ? cand_q : acc_code_q;
    step_d     = step_chg ? new_step : step_q;
    inv_d      = bad_code ? 1'b1 : (step_chg ? 1'b0 : inv_q);

    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PERIOD_W'(1);
    if (step_chg) cnt_d = PERIOD_W'(1);
    period_d = step_chg ? cnt_q : period_q;
    pv_d     = step_chg && have_prev_q && !stalled;

    seq_d = seq_q;
    if (!enable_i) seq_d = 1'b0;
    else if (step_chg && !exempt_q && !stalled && !adjacent) seq_d = 1'b1;

    exempt_d = exempt_q;
    if (!enable_i) exempt_d = 1'b1;
    else if (step_chg) exempt_d = 1'b0;
    else if (stalled) exempt_d = 1'b1;

    have_prev_d = have_prev_q;
    if (step_chg) have_prev_d = 1'b1;
    else if (stalled) have_prev_d = 1'b0;

    // A step change on the threshold cycle reloads cnt, so it wins over stall.
    stall_d = enable_i && (32'(cnt_d) >= STALL_CYCLES);

    live       = (acc_code_d != 3'b000) && (acc_code_d != 3'b111);
    drive_step = dir_i ? ((step_d >= 3'd3) ? step_d - 3'd3 : step_d + 3'd3) : step_d;
    status_d   = 6'b000000;
    if (enable_i && live && !seq_d && !stall_d) status_d = drive_pattern(drive_step);
  end

  // Registered state and outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_code_q  <= 3'b000;
      step_q      <= 3'd0;
      cnt_q       <= '0;
      period_q    <= '0;
      pv_q        <= 1'b0;
      inv_q       <= 1'b0;
      seq_q       <= 1'b0;
      stall_q     <= 1'b0;
      have_prev_q <= 1'b0;
      exempt_q    <= 1'b1;
      status_q    <= 6'b000000;
    end else begin
      acc_code_q  <= acc_code_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      pv_q        <= pv_d;
      inv_q       <= inv_d;
      seq_q       <= seq_d;
      stall_q     <= stall_d;
      have_prev_q <= have_prev_d;
      exempt_q    <= exempt_d;
      status_q    <= status_d;
    end
  end

  assign status_o       = status_q;
  assign step_o         = step_q;
  assign period_o       = period_q;
  assign period_valid_o = pv_q;
  assign fault_o        = inv_q | seq_q;
  assign stall_o        = stall_q;

endmodule

// File: tb/tb_hall_commutator.sv
// Bench for hall_commutator: directed scenarios with literal expectations plus
// randomized Hall sequences, all outputs compared every cycle to a model.
module tb_hall_commutator;

  localparam int DB    = 4;
  localparam int STALL = 200;
  localparam int PW    = 10;
  localparam int CMAX  = (1 << PW) - 1;

  // ---------------- clock / reset ----------------
  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          dir   = 1'b0;
  logic [2:0]    hall  = 3'b000;
  logic [5:0]    status;
  logic [2:0]    step;
  logic [PW-1:0] period;
  logic          pv, fault, stall;

  always #5 clk = ~clk;

  hall_commutator #(.DEBOUNCE(DB), .STALL_CYCLES(STALL), .PERIOD_W(PW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .dir_i(dir), .hall_i(hall),
    .status_o(status), .step_o(step), .period_o(period),
    .period_valid_o(pv), .fault_o(fault), .stall_o(stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         step_of[8]     = '{-1, 0, 2, 1, 4, 5, 3, -1};
  logic [2:0] code_of_step[6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  logic [5:0] fwd_tab[6] = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};
  logic [5:0] rev_tab[6] = '{6'b011000, 6'b010010, 6'b000110, 6'b100100, 6'b100001, 6'b001001};

  logic [2:0] pipe_q[$];   // hall samples in flight through the synchroniser
  logic [2:0] run_val, m_acc;
  int         run_len, m_step, m_cnt, m_period;
  logic       m_pv, m_inv, m_seq, m_stall, m_have_prev, m_first;
  logic [5:0] m_status;

  task automatic m_reset();
    pipe_q = '{3'b000, 3'b000};
    run_val = 3'b000; run_len = 1; m_acc = 3'b000;
    m_step = 0; m_cnt = 0; m_period = 0;
    m_pv = 0; m_inv = 0; m_seq = 0; m_stall = 0; m_status = 6'b0;
    m_have_prev = 0; m_first = 1;
  endtask

  task automatic m_clock();
    logic [2:0] s;
    logic chg, stalled;
    int ns, diff;
    s = pipe_q.pop_front();
    pipe_q.push_back(hall);
    if (s == run_val) begin
      if (run_len < 100) run_len++;
    end else begin
      run_val = s; run_len = 1;
    end
    stalled = (m_cnt >= STALL);
    chg = 0;
    m_pv = 0;
    if (run_len >= DB + 1 && s != m_acc) begin
      m_acc = s;
      if (step_of[s] < 0) m_inv = 1;
      else begin
        ns = step_of[s];
        diff = (ns - m_step + 6) % 6;
        if (en && !m_first && !stalled && diff != 1 && diff != 5) m_seq = 1;
        m_pv = m_have_prev && !stalled;
        m_period = m_cnt; m_cnt = 1; m_step = ns;
        m_have_prev = 1; m_first = 0; m_inv = 0; chg = 1;
      end
    end
    if (!chg) begin
      if (m_cnt < CMAX) m_cnt++;
      if (stalled) begin m_have_prev = 0; m_first = 1; end
    end
    if (!en) begin m_seq = 0; m_first = 1; end
    m_stall = en && (m_cnt >= STALL);
    m_status = (en && step_of[m_acc] >= 0 && !m_seq && !m_stall) ?
               (dir ? rev_tab[m_step] : fwd_tab[m_step]) : 6'b0;
  endtask

  // Model tracks the asynchronous reset as soon as it asserts.
  always @(negedge rst_n) m_reset();

  // Per-cycle compare of every output against the model.
  always @(posedge clk) begin
    if (!rst_n) m_reset(); else m_clock();
    #1;
    chk("status", 32'(status), 32'(m_status));
    chk("step",   32'(step),   32'(m_step));
    chk("period", 32'(period), 32'(m_period));
    chk("pvalid", 32'(pv),     32'(m_pv));
    chk("fault",  32'(fault),  32'(m_inv | m_seq));
    chk("stall",  32'(stall),  32'(m_stall));
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a code at a negedge and pin the outputs at the 7th following edge.
  task automatic pin(input logic [2:0] code, input int exp_step, input logic [5:0] exp_status,
                     input logic exp_pv, input int exp_period, input int hold_n);
    hall = code;
    repeat (7) @(posedge clk);
    #1;
    chk("pin_step",   32'(step),   32'(exp_step));
    chk("pin_status", 32'(status), 32'(exp_status));
    chk("pin_pv",     32'(pv),     32'(exp_pv));
    if (exp_period != 0) chk("pin_period", 32'(period), 32'(exp_period));
    @(negedge clk);
    repeat (hold_n - 7) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int cur_step;
    logic [2:0] saved;
    hold(3);
    chk("rst_status", 32'(status), 0);
    chk("rst_step",   32'(step),   0);
    chk("rst_period", 32'(period), 0);
    chk("rst_pv",     32'(pv),     0);
    chk("rst_fault",  32'(fault),  0);
    chk("rst_stall",  32'(stall),  0);
    rst_n = 1; en = 1; dir = 0;

    // forward rotation, 50-cycle steps
    pin(3'b001, 0, 6'b100100, 0, 0, 50);
    pin(3'b011, 1, 6'b100001, 1, 50, 50);
    pin(3'b010, 2, 6'b001001, 1, 50, 50);
    pin(3'b110, 3, 6'b011000, 1, 50, 50);
    pin(3'b100, 4, 6'b010010, 1, 50, 50);
    pin(3'b101, 5, 6'b000110, 1, 50, 50);
    pin(3'b001, 0, 6'b100100, 1, 50, 50);

    // reverse rotation
    dir = 1;
    pin(3'b011, 1, 6'b010010, 1, 50, 50);
    pin(3'b010, 2, 6'b000110, 1, 50, 50);
    pin(3'b110, 3, 6'b100100, 1, 50, 50);
    pin(3'b100, 4, 6'b100001, 1, 50, 50);
    pin(3'b101, 5, 6'b001001, 1, 50, 50);
    dir = 0;
    @(posedge clk); #1;
    chk("dir_swap_fwd", 32'(status), 32'(6'b000110));
    @(negedge clk);
    dir = 1;
    @(posedge clk); #1;
    chk("dir_swap_rev", 32'(status), 32'(6'b001001));
    @(negedge clk);
    pin(3'b001, 0, 6'b011000, 1, 52, 30);
    dir = 0;

    // glitch rejection
    hall = 3'b011;
    hold(3);
    hall = 3'b001;
    hold(12);
    chk("glitch_step",   32'(step),   0);
    chk("glitch_status", 32'(status), 32'(6'b100100));

    // invalid code fault, cleared by a valid code
    hall = 3'b111;
    hold(20);
    chk("inv_fault",  32'(fault),  1);
    chk("inv_status", 32'(status), 0);
    pin(3'b011, 1, 6'b100001, 1, 0, 20);
    chk("inv_clear", 32'(fault), 0);

    // sequence error is sticky until enable drops
    pin(3'b100, 4, 6'b000000, 1, 20, 20);
    chk("seq_fault", 32'(fault), 1);
    pin(3'b101, 5, 6'b000000, 1, 20, 20);
    pin(3'b001, 0, 6'b000000, 1, 20, 20);
    chk("seq_sticky", 32'(fault), 1);
    en = 0;
    @(posedge clk); #1;
    chk("seq_en_clear", 32'(fault), 0);
    chk("en_low_status", 32'(status), 0);
    @(negedge clk);
    en = 1;
    @(posedge clk); #1;
    chk("en_rise_status", 32'(status), 32'(6'b100100));
    @(negedge clk);
    pin(3'b110, 3, 6'b011000, 1, 0, 20);
    chk("en_rise_exempt", 32'(fault), 0);

    // stall after step 2
    hall = 3'b010;
    repeat (7) @(posedge clk);
    #1;
    chk("stall_pre_step", 32'(step), 2);
    n = 0;
    while (stall !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_after", 32'(n), 199);
    chk("stall_status", 32'(status), 0);
    @(negedge clk);
    pin(3'b011, 1, 6'b100001, 0, 0, 20);
    chk("stall_clear", 32'(stall), 0);
    pin(3'b010, 2, 6'b001001, 1, 20, 20);

    // asynchronous reset mid-rotation
    hall = 3'b110;
    hold(3);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_status", 32'(status), 0);
    chk("arst_step",   32'(step),   0);
    chk("arst_period", 32'(period), 0);
    chk("arst_pv",     32'(pv),     0);
    chk("arst_fault",  32'(fault),  0);
    chk("arst_stall",  32'(stall),  0);
    hold(3);
    hall = 3'b100;
    rst_n = 1;
    hold(12);
    chk("arst_first_fault",  32'(fault),  0);
    chk("arst_first_step",   32'(step),   4);
    chk("arst_first_status", 32'(status), 32'(6'b010010));

    // randomized phase
    cur_step = 4;
    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60) begin
        if ($urandom_range(0, 3) == 0) cur_step = (cur_step + 5) % 6;
        else cur_step = (cur_step + 1) % 6;
        hall = code_of_step[cur_step];
        hold($urandom_range(1, 60));
      end else if (r < 68) begin
        hall = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
        hold($urandom_range(1, 30));
      end else if (r < 76) begin
        hall = 3'($urandom_range(0, 7));
        if (step_of[hall] >= 0) cur_step = step_of[hall];
        hold($urandom_range(1, 40));
      end else if (r < 84) begin
        saved = hall;
        hall = 3'($urandom_range(0, 7));
        hold($urandom_range(1, 6));
        hall = saved;
        hold(10);
      end else if (r < 90) begin
        en = 0;
        hold($urandom_range(1, 20));
        en = 1;
      end else if (r < 95) begin
        dir = ~dir;
        hold($urandom_range(1, 10));
      end else begin
        hold($urandom_range(150, 1300));
      end
    end

    hold(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hall_commutator.md
# hall_commutator

Decodes the three Hall-effect sensors of one BLDC motor into a six-step commutation state and drives the 6-bit `status` bus consumed by the H-bridge signal generator. Hall inputs are synchronised and debounced before use. The block also checks step sequencing, measures the period between steps for the speed loop, and blanks the bridge on sensor faults or stall. It sits between the motor sensor pins and the PWM/H-bridge signal generation stage, one instance per motor.

## Interface
- `DEBOUNCE`, default 4: cycles a synchronised Hall code must be stable before it is accepted (≥1).
- `STALL_CYCLES`, default 100000: cycles without an accepted step change before stall is declared.
- `PERIOD_W`, default 20: width of the period counter and output.
- `clk_i` in, 1: single clock.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `enable_i` in, 1: motor run enable; low blanks the bridge and clears faults.
- `dir_i` in, 1: 0 = forward, 1 = reverse.
- `hall_i` in, 3: raw Hall sensors {C,B,A}, asynchronous.
- `status_o` out, 6: bridge enables {AH,AL,BH,BL,CH,CL}; bits 5/3/1 are high sides (PWM-gated downstream), bits 4/2/0 are low sides.
- `step_o` out, 3: current accepted step 0–5.
- `period_o` out, PERIOD_W: cycles between the last two accepted step changes, saturating.
- `period_valid_o` out, 1: one-cycle strobe when `period_o` updates.
- `fault_o` out, 1: invalid Hall code or sequence error.
- `stall_o` out, 1: no step change for STALL_CYCLES.

## Operation
- **Synchroniser:** 2-flop on `hall_i`.
- **Debounce:**
  - Candidate register plus counter.
  - When the synced code differs from the candidate, load the candidate and clear the counter.
  - The candidate is accepted once it has been stable for DEBOUNCE cycles and differs from the accepted code.
- **Step map (forward sequence, code→step):** 001→0, 011→1, 010→2, 110→3, 100→4, 101→5.
- **Forward drive per step:**
  - 0: A+B− = 100100
  - 1: A+C− = 100001
  - 2: B+C− = 001001
  - 3: B+A− = 011000
  - 4: C+A− = 010010
  - 5: C+B− = 000110
- **Reverse drive:** same step with high/low swapped:
  - 0: 011000
  - 1: 010010
  - 2: 000110
  - 3: 100100
  - 4: 100001
  - 5: 001001
- **Invalid codes (000/111):**
  - When accepted, `fault_o` = 1 and `status_o` = 0.
  - Both hold while the code persists.
  - A subsequent valid code clears this fault.
- **Sequence error:**
  - Fires when an accepted valid step is not step±1 mod 6 of the previous valid step.
  - Sets a sticky fault (`fault_o` = 1, `status_o` = 0).
  - Cleared only by `enable_i` = 0 or reset.
  - The first valid step after reset, stall or enable rise is exempt.
- **Period counter:**
  - `cnt` increments every cycle, saturating at 2^PERIOD_W−1.
  - On an accepted step change: `period_o` ← `cnt`, `cnt` ← 1.
  - `period_valid_o` pulses only if a previous step change exists since reset/stall; otherwise there is no strobe.
- **Stall:**
  - When `cnt` reaches STALL_CYCLES, `stall_o` = 1 and `status_o` = 0.
  - Cleared by the next accepted step change, which is treated as a first step: no period strobe and no sequence check.
- **`enable_i` = 0:**
  - `status_o` = 0.
  - Sticky fault and stall are cleared.
  - Decoding, `step_o` and period measurement continue.
- **`dir_i` change:** takes effect on `status_o` the next cycle with no other action.
- **Until the first valid code is accepted after reset:** `status_o` = 0.

## Timing
- **Reset values:** `status_o` = 0, `step_o` = 0, `period_o` = 0, `period_valid_o` = 0, `fault_o` = 0, `stall_o` = 0. `cnt`, debounce and sync state cleared; "no previous step" flag set.
- **Latency:** with `hall_i` changed and held from edge t, `step_o`, `status_o` and `period_valid_o` update at edge t+DEBOUNCE+3.
- All outputs are registered.
- A glitch shorter than DEBOUNCE synced cycles is never accepted.
- Simultaneous stall threshold and accepted step change: the step change wins (no stall).
- `enable_i` falling while a sticky fault is set clears the fault the next cycle.

## Test plan
1. **Forward rotation:** DEBOUNCE=4, `enable_i`=1, `dir_i`=0, `hall_i` steps 001,011,010,110,100,101 every 50 cycles → `status_o` sequence 100100,100001,001001,011000,010010,000110, each 7 cycles after the change. `period_o` = 50 with a strobe from the second change on.
2. **Reverse:** same sequence with `dir_i`=1 → `status_o` 011000,010010,000110,100100,100001,001001. Toggling `dir_i` mid-step swaps the pattern 1 cycle later.
3. **Glitch rejection:** `hall_i` 001→011 for 3 cycles then back to 001 → `step_o` and `status_o` unchanged, no strobe.
4. **Faults:**
   - `hall_i`=111 held → `fault_o`=1, `status_o`=0; the fault clears on return to a valid code.
   - Jump 001→110 → sticky `fault_o`; it persists after valid rotation resumes and clears one cycle after `enable_i`=0.
5. **Stall:**
   - STALL_CYCLES=200, hold `hall_i` after step 2 → `stall_o`=1 and `status_o`=0 at 200 counts.
   - The next step change clears stall with no `period_valid_o`.
6. **Async reset mid-rotation:** all outputs go to 0 immediately. The first valid code afterwards is accepted without `fault_o`.
